// File: rtl/branch_prediction_unit_if.sv
// rtl/branch_prediction_unit_if.sv - IF/ID signal bundle between the pipeline and the branch predictor
// master: pipeline side driving fetch/resolve info; slave: the predictor.
interface branch_prediction_unit_if;
  logic [31:0] IF_PC;
  logic [31:0] IF_Inst;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        stall;
  logic        ID_Branch_valid;
  logic [31:0] ID_PC;
  logic        ID_taken;
  logic [31:0] ID_target;
  logic        ID_predicted;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output IF_PC, IF_Inst, stall, ID_Branch_valid, ID_PC, ID_taken, ID_target, ID_predicted,
    input  predict_taken, predict_target, flush, redirect_pc, branch_count, mispredict_count
  );

  modport slave (
    input  IF_PC, IF_Inst, stall, ID_Branch_valid, ID_PC, ID_taken, ID_target, ID_predicted,
    output predict_taken, predict_target, flush, redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_prediction_unit.sv
// rtl/branch_prediction_unit.sv - 2-bit saturating counter branch predictor with ID-stage mispredict recovery
// Branch/mispredict statistics counters are built only when BP_STATS_EN is defined.
module branch_prediction_unit #(
  parameter int INDEX_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_prediction_unit_if.slave  bp
);

  localparam int         ENTRIES       = 1 << INDEX_BITS;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [1:0] CTR_RESET     = 2'b01;
  localparam logic [1:0] CTR_MAX       = 2'b11;
  localparam logic [1:0] CTR_MIN       = 2'b00;

  logic [1:0]            r_table [ENTRIES];

  logic                  w_if_is_branch;
  logic [INDEX_BITS-1:0] w_if_index;
  logic [INDEX_BITS-1:0] w_id_index;
  logic [31:0]           w_b_imm;
  logic                  w_resolve;
  logic                  w_mispredict;
  logic [1:0]            w_cur_ctr;
  logic [1:0]            w_next_ctr;
  logic                  w_unused_inst_bits;

  // IF stage: decode, index and B-immediate
  assign w_if_is_branch = (bp.IF_Inst[6:2] == OPCODE_BRANCH);
  assign w_if_index     = bp.IF_PC[INDEX_BITS+1:2];
  assign w_b_imm        = {{19{bp.IF_Inst[31]}}, bp.IF_Inst[31], bp.IF_Inst[7],
                           bp.IF_Inst[30:25], bp.IF_Inst[11:8], 1'b0};
  assign w_unused_inst_bits = ^{bp.IF_Inst[24:12], bp.IF_Inst[1:0]};

  // Table is read before any same-cycle write lands, so IF sees the pre-update counter
  assign bp.predict_taken  = w_if_is_branch & r_table[w_if_index][1];
  assign bp.predict_target = bp.IF_PC + w_b_imm;

  // ID stage resolution
  assign w_id_index   = bp.ID_PC[INDEX_BITS+1:2];
  assign w_resolve    = bp.ID_Branch_valid & ~bp.stall;
  assign w_mispredict = w_resolve & (bp.ID_taken != bp.ID_predicted);
  assign bp.flush       = rst & w_mispredict;
  assign bp.redirect_pc = bp.ID_taken ? bp.ID_target : (bp.ID_PC + 32'd4);

  assign w_cur_ctr = r_table[w_id_index];

  always_comb begin
    w_next_ctr = w_cur_ctr;
    if (bp.ID_taken) begin
      if (w_cur_ctr != CTR_MAX) begin
        w_next_ctr = w_cur_ctr + 2'd1;
      end
    end else begin
      if (w_cur_ctr != CTR_MIN) begin
        w_next_ctr = w_cur_ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CTR_RESET;
      end
    end else if (w_resolve) begin
      r_table[w_id_index] <= w_next_ctr;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      if (w_resolve && (r_branch_count != 32'hFFFF_FFFF)) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;
`else
  assign bp.branch_count     = 32'd0;
  assign bp.mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_prediction_unit.sv
// tb/tb_branch_prediction_unit.sv - directed and randomized check of branch_prediction_unit against a behavioural model
module tb_branch_prediction_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_prediction_unit_if bp_if();

  branch_prediction_unit #(.INDEX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          m_ctr [16];
  int          m_branches;
  int          m_mispredicts;
  logic [31:0] cur_imm;
  bit          cur_is_branch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_branches();
`ifdef BP_STATS_EN
    return m_branches;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_mispredicts();
`ifdef BP_STATS_EN
    return m_mispredicts;
`else
    return 0;
`endif
  endfunction

  function automatic int lit_stat(input int v);
`ifdef BP_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Reference model: one counter per index, saturating 0..3, plus running totals
  initial begin
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_branches = 0;
    m_mispredicts = 0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_branches = 0;
      m_mispredicts = 0;
    end else if (bp_if.ID_Branch_valid && !bp_if.stall) begin
      int k;
      k = int'((bp_if.ID_PC >> 2) % 16);
      if (bp_if.ID_taken) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
      else                m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
      m_branches++;
      if (bp_if.ID_taken != bp_if.ID_predicted) m_mispredicts++;
    end
  end

  always @(negedge clk) begin
    int  k;
    bit  e_flush;
    k = int'((bp_if.IF_PC >> 2) % 16);
    e_flush = rst && bp_if.ID_Branch_valid && !bp_if.stall && (bp_if.ID_taken != bp_if.ID_predicted);
    check("predict_taken", {31'd0, bp_if.predict_taken}, {31'd0, (cur_is_branch && m_ctr[k] >= 2)});
    if (cur_is_branch) check("predict_target", bp_if.predict_target, bp_if.IF_PC + cur_imm);
    check("flush", {31'd0, bp_if.flush}, {31'd0, e_flush});
    if (e_flush)
      check("redirect_pc", bp_if.redirect_pc, bp_if.ID_taken ? bp_if.ID_target : bp_if.ID_PC + 32'd4);
    check("branch_count", bp_if.branch_count, exp_branches());
    check("mispredict_count", bp_if.mispredict_count, exp_mispredicts());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if_branch(input logic [31:0] pc, input logic [12:0] imm);
    logic [31:0] filler;
    filler = $urandom;
    bp_if.IF_PC   = pc;
    bp_if.IF_Inst = {imm[12], imm[10:5], filler[24:12], imm[4:1], imm[11], 7'b1100011};
    cur_imm       = {{19{imm[12]}}, imm[12:1], 1'b0};
    cur_is_branch = 1'b1;
  endtask

  task automatic set_if_other(input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] w;
    w = inst;
    if (w[6:2] == 5'b11000) w[2] = 1'b1;
    bp_if.IF_PC   = pc;
    bp_if.IF_Inst = w;
    cur_imm       = 32'd0;
    cur_is_branch = 1'b0;
  endtask

  task automatic set_id(input bit v, input bit st, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit pr);
    bp_if.ID_Branch_valid = v;
    bp_if.stall           = st;
    bp_if.ID_PC           = pc;
    bp_if.ID_taken        = tk;
    bp_if.ID_target       = tgt;
    bp_if.ID_predicted    = pr;
  endtask

  initial begin
    rst = 1'b0;
    set_if_branch(32'h40, 13'd16);
    set_id(1, 0, 32'h40, 1, 32'h50, 0);
    #12;
    check("rst_flush_forced_low", {31'd0, bp_if.flush}, 32'd0);
    check("rst_branch_count", bp_if.branch_count, 32'd0);
    check("rst_mispredict_count", bp_if.mispredict_count, 32'd0);
    step();
    rst = 1'b1;
    set_id(0, 0, 32'h0, 0, 32'h0, 0);

    // first fetch after reset predicts not-taken
    #1;
    check("lit_pt_after_reset", {31'd0, bp_if.predict_taken}, 32'd0);
    check("lit_target_0x50", bp_if.predict_target, 32'h50);

    // two taken mispredicts train 01 -> 10 -> 11
    step();
    set_id(1, 0, 32'h40, 1, 32'h50, 0);
    #1;
    check("lit_flush_1", {31'd0, bp_if.flush}, 32'd1);
    check("lit_redirect_1", bp_if.redirect_pc, 32'h50);
    step();
    check("lit_flush_2", {31'd0, bp_if.flush}, 32'd1);
    check("lit_redirect_2", bp_if.redirect_pc, 32'h50);
    step();
    set_id(0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check("lit_pt_trained", {31'd0, bp_if.predict_taken}, 32'd1);

    // correct prediction, then a not-taken mispredict
    step();
    set_id(1, 0, 32'h40, 1, 32'h50, 1);
    #1;
    check("lit_no_flush_correct", {31'd0, bp_if.flush}, 32'd0);
    step();
    set_id(1, 0, 32'h40, 0, 32'h50, 1);
    #1;
    check("lit_flush_nt", {31'd0, bp_if.flush}, 32'd1);
    check("lit_redirect_pc4", bp_if.redirect_pc, 32'h44);
    step();
    set_id(0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check("lit_pt_weak_taken", {31'd0, bp_if.predict_taken}, 32'd1);
    check("lit_branch_count_4", bp_if.branch_count, lit_stat(4));
    check("lit_mispredict_count_3", bp_if.mispredict_count, lit_stat(3));

    // mispredict held by stall for two cycles
    step();
    set_id(1, 1, 32'h40, 0, 32'h50, 1);
    #1;
    check("lit_stall_flush_a", {31'd0, bp_if.flush}, 32'd0);
    step();
    check("lit_stall_flush_b", {31'd0, bp_if.flush}, 32'd0);
    step();
    bp_if.stall = 1'b0;
    #1;
    check("lit_stall_pt_unchanged", {31'd0, bp_if.predict_taken}, 32'd1);
    check("lit_stall_release_flush", {31'd0, bp_if.flush}, 32'd1);
    step();
    set_id(0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check("lit_single_flush", {31'd0, bp_if.flush}, 32'd0);
    check("lit_pt_after_one_update", {31'd0, bp_if.predict_taken}, 32'd0);

    // aliasing between 0x40 and 0x80
    step();
    set_id(1, 0, 32'h40, 1, 32'h50, 1);
    step();
    step();
    set_id(0, 0, 32'h0, 0, 32'h0, 0);
    set_if_branch(32'h80, 13'd16);
    #1;
    check("lit_alias_pt", {31'd0, bp_if.predict_taken}, 32'd1);
    check("lit_alias_target", bp_if.predict_target, 32'h90);
    set_if_other(32'h40, 32'h0010_0093);
    #1;
    check("lit_addi_pt", {31'd0, bp_if.predict_taken}, 32'd0);

    // asynchronous reset in the middle of a resolving cycle
    step();
    set_if_branch(32'h40, 13'd16);
    set_id(1, 0, 32'h40, 1, 32'h50, 0);
    #1;
    check("lit_pre_reset_pt", {31'd0, bp_if.predict_taken}, 32'd1);
    rst = 1'b0;
    #1;
    check("lit_midrst_flush", {31'd0, bp_if.flush}, 32'd0);
    check("lit_midrst_pt", {31'd0, bp_if.predict_taken}, 32'd0);
    check("lit_midrst_branch_count", bp_if.branch_count, 32'd0);
    check("lit_midrst_mispredict_count", bp_if.mispredict_count, 32'd0);
    step();
    rst = 1'b1;
    set_id(0, 0, 32'h0, 0, 32'h0, 0);

    // every entry must be 01: one taken update flips its prediction
    for (int i = 0; i < 16; i++) begin
      step();
      set_if_branch(32'h1000 + 32'(i * 4), 13'h1FF8);
      set_id(1, 0, 32'h2000 + 32'(i * 4), 1, 32'h0, 0);
      #1;
      check("lit_entry_pre", {31'd0, bp_if.predict_taken}, 32'd0);
      step();
      set_id(0, 0, 32'h0, 0, 32'h0, 0);
      #1;
      check("lit_entry_post", {31'd0, bp_if.predict_taken}, 32'd1);
    end

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!rst) rst = 1'b1;
      if ($urandom_range(0, 9) < 7) set_if_branch($urandom & 32'hFFFF_FFFC, 13'($urandom));
      else                          set_if_other($urandom & 32'hFFFF_FFFC, $urandom);
      set_id($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
             1'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b0;
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_prediction_unit.md
# branch_prediction_unit

Dynamic branch predictor and mispredict-recovery unit for the 5-stage RISC-V pipeline. Predicts conditional branches in IF with a PC-indexed table of 2-bit saturating counters and supplies the predicted target. Resolves each branch in ID, where it raises a one-cycle flush and redirect PC on a mispredict. It is the consumer of the ID-stage load-use stall: while `stall` is high, branch resolution is held and no flush or table update occurs.

## Interface

Parameters:
- `INDEX_BITS`, default 4: the table has 2^INDEX_BITS entries, indexed by PC[INDEX_BITS+1:2].

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `IF_PC`  in  32  PC of the instruction being fetched.
- `IF_Inst`  in  32  instruction being fetched.
- `predict_taken`  out  1  IF-stage prediction. Carried down the pipeline in IF/ID.
- `predict_target`  out  32  IF_PC + B-immediate.
- `stall`  in  1  ID-stage load-use stall from the hazard unit.
- `ID_Branch_valid`  in  1  a conditional branch is in ID and its outcome is resolved this cycle.
- `ID_PC`  in  32  PC of the branch in ID.
- `ID_taken`  in  1  actual outcome of the branch.
- `ID_target`  in  32  actual taken target of the branch.
- `ID_predicted`  in  1  `predict_taken` value captured for this branch in IF/ID.
- `flush`  out  1  squash the instruction in IF/ID and redirect fetch.
- `redirect_pc`  out  32  correct fetch PC. Valid when `flush`=1.
- `branch_count`  out  32  number of resolved branches. Present only with the statistics feature (see Configuration).
- `mispredict_count`  out  32  number of mispredicted branches. Present only with the statistics feature (see Configuration).

## Operation

Branch detection:
- An instruction is a branch when IF_Inst[6:2] == `OPCODE_Branch` (5'b11000).

IF-stage prediction (combinational):
- `predict_taken` = is_branch & table[IF index][1].
- `predict_target` = IF_PC + sign-extended B-immediate {IF_Inst[31], IF_Inst[7], IF_Inst[30:25], IF_Inst[11:8], 1'b0}, as 32-bit wrap-around addition.
- `predict_taken` is 0 for non-branches, whatever the counter value. `predict_target` is don't-care in that case.

ID-stage resolution. Define `resolve` = ID_Branch_valid & ~stall.
- `flush` = resolve & (ID_taken != ID_predicted).
- `redirect_pc` = ID_taken ? ID_target : ID_PC + 4, with 32-bit wrap-around.
- When `flush` is 0, `redirect_pc` is don't-care.

Counter update (only when `resolve`=1). Counter states: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Taken: the counter increments and saturates at 11.
- Not taken: the counter decrements and saturates at 00.
- Only the entry at ID index PC[INDEX_BITS+1:2] changes.

Aliasing: PCs with equal index bits share one entry. There is no tag check.

## Timing

- Prediction has zero latency: it is combinational from IF_PC and IF_Inst.
- `flush` and `redirect_pc` are combinational and valid in the resolving cycle. `flush` is high for exactly one cycle per mispredicted branch.
- The table is written on the rising `clk` edge that ends a `resolve` cycle.
- No read/write bypass: if the IF and ID indices are equal in the same cycle, IF reads the pre-update counter. The new value is visible from the next cycle.
- Stall: while `stall`=1 there is no flush, no table write and no statistics change. The branch resolves once, in the first cycle with `stall`=0 and ID_Branch_valid=1.
- Reset:
  - Asserting `rst` low immediately sets every entry to 01 and clears both statistics counters to 0, regardless of `clk`.
  - After reset, every branch predicts not-taken.
  - Combinational outputs follow their inputs during reset, except `flush`, which is forced to 0 while `rst`=0.
  - Reset asserted mid-operation discards all history. A resolution pending in that cycle is dropped.

## Configuration

- Macro: `BP_STATS_EN`.
- Defined: `branch_count` increments on every `resolve` cycle. `mispredict_count` increments on every `flush` cycle. Both are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- Undefined: both counters and their logic are removed, and both outputs are tied to 32'd0.

## Test plan

- Reset, then fetch a branch at IF_PC=0x40 with B-immediate +16: `predict_taken`=0, `predict_target`=0x50.
- Resolve 0x40 taken twice (ID_predicted=0, ID_target=0x50): `flush`=1 both times, `redirect_pc`=0x50, entry 01→10→11. A later fetch of 0x40 gives `predict_taken`=1.
- Resolve 0x40 taken with ID_predicted=1: `flush`=0, entry stays at 11. Then resolve it not-taken: `flush`=1, `redirect_pc`=0x44, entry becomes 10.
- ID_Branch_valid=1 with `stall`=1 for 2 cycles, mispredicted: `flush`=0 and no update during the stall. Drop `stall`: `flush`=1 for exactly one cycle, one update.
- Alias, INDEX_BITS=4: train 0x40 to 11, then fetch a branch at 0x80: `predict_taken`=1. Fetch an ADDI at 0x40: `predict_taken`=0.
- `BP_STATS_EN` defined, run the three scenarios above from reset: `branch_count`=4, `mispredict_count`=3. Assert `rst` mid-cycle: both read 0 at once and all entries read 01.
